// File: rtl/param_mem_sorter_pkg.sv
// Shared types and helpers for the in-memory bubble sorter.
package param_mem_sorter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SORT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Largest number of swaps a bubble sort can make on 'depth' words.
   function automatic int max_swaps(input int depth);
      return depth * (depth - 1) / 2;
   endfunction

endpackage

// File: rtl/param_mem_sorter_if.sv
// Host-side bus of the sorter: load/read port, start/done level handshake,
// sort mode selects and status.
//
// Handshake: the host raises s and holds it high. The sorter leaves IDLE on
// the first edge that sees s=1 with Wrinit=0 and raises busy. When the sort
// ends, busy drops and done rises. done stays high until the host lowers s.
// The sorter returns to IDLE on the first edge that sees s=0 in DONE. Loads
// (Wrinit) are honoured only in IDLE. Reads (Rd) are honoured in IDLE and
// DONE and return data one cycle later on DataOut.
interface param_mem_sorter_if
   import param_mem_sorter_pkg::*;
#(
   parameter int N = 8,
   parameter int L = 3
);
   logic           s;
   logic           Wrinit;
   logic           Rd;
   logic [L-1:0]   Radd;
   logic [N-1:0]   Datain;
   logic           desc;
   logic           sgn;
   logic [N-1:0]   DataOut;
   logic           done;
   logic           busy;
   logic [2*L-1:0] swap_cnt;
   state_t         dbg_state;

   modport master (
      output s, Wrinit, Rd, Radd, Datain, desc, sgn,
      input  DataOut, done, busy, swap_cnt, dbg_state
   );

   modport slave (
      input  s, Wrinit, Rd, Radd, Datain, desc, sgn,
      output DataOut, done, busy, swap_cnt, dbg_state
   );
endinterface

// File: rtl/param_mem_sorter_cmp.sv
// Out-of-order detector for one adjacent pair (a precedes b).
// Equal words never request a swap, which keeps the sort stable.
module sort_cmp #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         desc_i,
   input  logic         sgn_i,
   output logic         swap_req_o
);
   logic [N-1:0] a_k;
   logic [N-1:0] b_k;

   // Flipping the MSB maps two's-complement order onto unsigned order.
   always_comb begin
      a_k        = {a_i[N-1] ^ sgn_i, a_i[N-2:0]};
      b_k        = {b_i[N-1] ^ sgn_i, b_i[N-2:0]};
      swap_req_o = desc_i ? (a_k < b_k) : (a_k > b_k);
   end
endmodule

// File: rtl/param_mem_sorter.sv
// In-place early-exit bubble sorter over a 2^L x N register file.
// It does one compare and one optional swap per clock.
module param_mem_sorter
   import param_mem_sorter_pkg::*;
#(
   parameter int N = 8,
   parameter int L = 3
) (
   input logic              clk,
   input logic              rst,
   param_mem_sorter_if.slave bus
);
   localparam int          DEPTH  = 1 << L;
   localparam int          CW     = 2 * L;
   localparam logic [L-1:0] LAST_J = L'(DEPTH - 2);

   logic [N-1:0]  mem_q [DEPTH];
   state_t        state_q;
   logic [L-1:0]  j_q;
   logic [L-1:0]  pass_q;
   logic          swapped_q;
   logic          desc_q;
   logic          sgn_q;
   logic          done_q;
   logic          busy_q;
   logic [N-1:0]  dout_q;
   logic [CW-1:0] swap_cnt_q;

   logic [L-1:0]  j_nx;
   logic [N-1:0]  a_w;
   logic [N-1:0]  b_w;
   logic          end_of_pass;
   logic          last_pass;
   logic          swap_req;

   // Current pair and end-of-pass detection. Pass p stops at j = DEPTH-2-p.
   always_comb begin
      j_nx        = j_q + L'(1);
      a_w         = mem_q[j_q];
      b_w         = mem_q[j_nx];
      end_of_pass = (j_q == (LAST_J - pass_q));
      last_pass   = (pass_q == LAST_J);
   end

   sort_cmp #(.N(N)) u_cmp (
      .a_i        (a_w),
      .b_i        (b_w),
      .desc_i     (desc_q),
      .sgn_i      (sgn_q),
      .swap_req_o (swap_req)
   );

   // Control FSM together with the register file, counters and registered status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         state_q    <= ST_IDLE;
         j_q        <= '0;
         pass_q     <= '0;
         swapped_q  <= 1'b0;
         desc_q     <= 1'b0;
         sgn_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         dout_q     <= '0;
         swap_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.Rd) dout_q <= mem_q[bus.Radd];
               if (bus.Wrinit) begin
                  // A load in the same cycle as start wins; start waits.
                  mem_q[bus.Radd] <= bus.Datain;
               end else if (bus.s) begin
                  state_q    <= ST_SORT;
                  desc_q     <= bus.desc;
                  sgn_q      <= bus.sgn;
                  swap_cnt_q <= '0;
                  pass_q     <= '0;
                  j_q        <= '0;
                  swapped_q  <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_SORT: begin
               if (swap_req) begin
                  mem_q[j_q]  <= b_w;
                  mem_q[j_nx] <= a_w;
                  swap_cnt_q  <= swap_cnt_q + CW'(1);
               end
               if (!end_of_pass) begin
                  j_q       <= j_nx;
                  swapped_q <= swapped_q | swap_req;
               end else if (!(swapped_q | swap_req) || last_pass) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  pass_q    <= pass_q + L'(1);
                  j_q       <= '0;
                  swapped_q <= 1'b0;
               end
            end
            ST_DONE: begin
               if (bus.Rd) dout_q <= mem_q[bus.Radd];
               if (!bus.s) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.DataOut   = dout_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.swap_cnt  = swap_cnt_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_param_mem_sorter.sv
// Directed bench for param_mem_sorter (N=8, L=3): table of load/sort/readback
// vectors plus hand sequences for load/start priority, read-during-write and
// reset during a sort.
module tb_param_mem_sorter;
   import param_mem_sorter_pkg::*;

   typedef struct {
      logic [7:0][7:0] din;
      logic            desc;
      logic            sgn;
      logic [7:0][7:0] exp;
      int              swaps;
      int              cycles;
      int              mode;    // 0 plain, 1 flip modes mid-sort, 2 write mid-sort
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vt [8];

   param_mem_sorter_if #(.N(8), .L(3)) bus ();

   param_mem_sorter #(.N(8), .L(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Clock: 10 ns period. Inputs change and outputs are sampled on negedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0][7:0] p8(input logic [7:0] a0, a1, a2, a3,
                                          input logic [7:0] a4, a5, a6, a7);
      logic [7:0][7:0] r;
      r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
      r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic load_words(input logic [7:0][7:0] d);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.Wrinit = 1'b1;
         bus.Radd   = 3'(i);
         bus.Datain = d[i];
      end
      @(negedge clk);
      bus.Wrinit = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [7:0][7:0] e);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.Rd   = 1'b1;
         bus.Radd = 3'(i);
         @(negedge clk);
         bus.Rd = 1'b0;
         check($sformatf("%s_rd%0d", name, i), int'(bus.DataOut), int'(e[i]));
      end
   endtask

   task automatic run_sort(input logic d, input logic g, input int mode,
                           input string name, output int cycles);
      bit done_seen;
      @(negedge clk);
      bus.s    = 1'b1;
      bus.desc = d;
      bus.sgn  = g;
      cycles    = 0;
      done_seen = 1'b0;
      for (int t = 0; t < 200 && !done_seen; t++) begin
         @(negedge clk);
         if (bus.busy) begin
            cycles++;
            if (mode == 1 && cycles == 3) begin
               bus.desc = ~d;
               bus.sgn  = ~g;
            end
            if (mode == 2 && cycles == 3) begin
               bus.Wrinit = 1'b1;
               bus.Radd   = 3'd3;
               bus.Datain = 8'hAA;
            end else if (mode == 2 && cycles == 4) begin
               bus.Wrinit = 1'b0;
            end
         end else if (bus.done) begin
            done_seen = 1'b1;
         end
      end
      check({name, "_done"}, int'(done_seen), 1);
      bus.Wrinit = 1'b0;
      bus.s      = 1'b0;
      bus.desc   = 1'b0;
      bus.sgn    = 1'b0;
      @(negedge clk);
      check({name, "_done_drop"}, int'(bus.done), 0);
   endtask

   task automatic apply_vec(input int k);
      int    cyc;
      string nm;
      nm = $sformatf("vec%0d", k);
      load_words(vt[k].din);
      run_sort(vt[k].desc, vt[k].sgn, vt[k].mode, nm, cyc);
      check({nm, "_cycles"}, cyc, vt[k].cycles);
      check({nm, "_swaps"}, int'(bus.swap_cnt), vt[k].swaps);
      read_check(nm, vt[k].exp);
   endtask

   initial begin
      logic [7:0][7:0] rev, asc, one8, sg, sg_s, sg_u, sg_d, zeros;
      int scnt;

      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      bus.s      = 1'b0;
      bus.Wrinit = 1'b0;
      bus.Rd     = 1'b0;
      bus.Radd   = '0;
      bus.Datain = '0;
      bus.desc   = 1'b0;
      bus.sgn    = 1'b0;

      rev   = p8(8'd16, 8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2);
      asc   = p8(8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16);
      one8  = p8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
      sg    = p8(8'h05, 8'hF0, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h05, 8'h01);
      sg_s  = p8(8'h80, 8'hF0, 8'hFF, 8'h00, 8'h01, 8'h05, 8'h05, 8'h7F);
      sg_u  = p8(8'h00, 8'h01, 8'h05, 8'h05, 8'h7F, 8'h80, 8'hF0, 8'hFF);
      sg_d  = p8(8'h7F, 8'h05, 8'h05, 8'h01, 8'h00, 8'hFF, 8'hF0, 8'h80);
      zeros = '0;

      vt[0] = '{din: rev,  desc: 1'b0, sgn: 1'b0, exp: asc,  swaps: max_swaps(8), cycles: 28, mode: 0};
      vt[1] = '{din: one8, desc: 1'b0, sgn: 1'b0, exp: one8, swaps: 0,  cycles: 7,  mode: 0};
      vt[2] = '{din: rev,  desc: 1'b1, sgn: 1'b0, exp: rev,  swaps: 0,  cycles: 7,  mode: 0};
      vt[3] = '{din: rev,  desc: 1'b0, sgn: 1'b0, exp: asc,  swaps: 28, cycles: 28, mode: 1};
      vt[4] = '{din: sg,   desc: 1'b0, sgn: 1'b1, exp: sg_s, swaps: 12, cycles: 22, mode: 0};
      vt[5] = '{din: sg,   desc: 1'b0, sgn: 1'b0, exp: sg_u, swaps: 17, cycles: 28, mode: 0};
      vt[6] = '{din: rev,  desc: 1'b0, sgn: 1'b0, exp: asc,  swaps: 28, cycles: 28, mode: 2};
      vt[7] = '{din: sg,   desc: 1'b1, sgn: 1'b1, exp: sg_d, swaps: 15, cycles: 25, mode: 0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_done", int'(bus.done), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_swap_cnt", int'(bus.swap_cnt), 0);
      check("rst_dataout", int'(bus.DataOut), 0);
      rst = 1'b0;
      read_check("rst_mem", zeros);

      // Load beats start in the same cycle
      @(negedge clk);
      bus.Wrinit = 1'b1;
      bus.s      = 1'b1;
      bus.Radd   = 3'd0;
      bus.Datain = 8'd9;
      @(negedge clk);
      bus.Wrinit = 1'b0;
      bus.s      = 1'b0;
      check("defer_start_busy", int'(bus.busy), 0);

      // Write and read together: DataOut gets the old word
      @(negedge clk);
      bus.Wrinit = 1'b1;
      bus.Rd     = 1'b1;
      bus.Radd   = 3'd0;
      bus.Datain = 8'h33;
      @(negedge clk);
      bus.Wrinit = 1'b0;
      bus.Rd     = 1'b0;
      check("rw_old_data", int'(bus.DataOut), 9);
      @(negedge clk);
      bus.Rd = 1'b1;
      @(negedge clk);
      bus.Rd = 1'b0;
      check("rw_new_data", int'(bus.DataOut), 8'h33);

      // Table-driven sorts
      for (int k = 0; k < 8; k++) apply_vec(k);

      // Reset five cycles into a sort
      load_words(rev);
      @(negedge clk);
      bus.s = 1'b1;
      scnt  = 0;
      for (int t = 0; t < 50 && scnt < 5; t++) begin
         @(negedge clk);
         if (bus.busy) scnt++;
      end
      check("midrst_reached_sort", scnt, 5);
      rst = 1'b1;
      #1;
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_done", int'(bus.done), 0);
      check("midrst_swap_cnt", int'(bus.swap_cnt), 0);
      @(negedge clk);
      rst   = 1'b0;
      bus.s = 1'b0;
      read_check("midrst_mem", zeros);

      // A fresh sort after the reset
      apply_vec(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/param_mem_sorter.md
Name: param_mem_sorter

Overview:
Parametrised successor to the team's 8-entry in-memory sorter. Holds 2^L words of N bits in an internal register file, loaded and read through a single address port. On start it sorts the contents in place with an early-exit bubble sort, one compare/swap per clock. Adds selectable ascending/descending order, signed/unsigned compare, a busy flag and a swap counter. Sits behind the same host load/start/read sequence as the existing sorter.

Parameters:
N, 8, data word width in bits (N >= 2)
L, 3, address width; DEPTH = 2^L entries (L >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
s  in  1  start; level, held high by host until done is seen
Wrinit  in  1  write enable for host load (IDLE only)
Rd  in  1  read enable (IDLE or DONE)
Radd  in  L  host address for write and read
Datain  in  N  host write data
desc  in  1  0 = ascending, 1 = descending; sampled at start
sgn  in  1  0 = unsigned, 1 = two's-complement compare; sampled at start
DataOut  out  N  registered read data
done  out  1  high in DONE state
busy  out  1  high in SORT state
swap_cnt  out  2L  swaps performed in the current/last sort

Behaviour:
- Reset (async, any state, including mid-sort): state IDLE; all memory words, DataOut, swap_cnt, pass/index counters and latched modes = 0; done = busy = 0.
- States: IDLE, SORT, DONE.
- IDLE: Wrinit=1 -> M[Radd] <= Datain at the edge. Rd=1 -> DataOut <= M[Radd] at the edge (1-cycle latency). Wrinit and Rd together: write occurs, DataOut gets the old contents. s=1 and Wrinit=0 -> SORT next edge; latch desc/sgn; clear swap_cnt, pass=0, j=0, swapped flag=0. s=1 with Wrinit=1: write wins and start is deferred.
- SORT: each cycle compare M[j] and M[j+1] using the latched modes.
  - Out of order means M[j] > M[j+1] (ascending) or M[j] < M[j+1] (descending).
  - Equal values are never swapped, so the sort is stable.
  - On a swap, both words are written that edge, swap_cnt increments and swapped is set.
  - If j < DEPTH-2-pass: j++.
  - Otherwise, at end of pass: if no swap occurred in this pass (including this cycle) or pass == DEPTH-2, go to DONE. Else pass++, j=0, swapped=0.
- SORT cycle counts: already-sorted input takes DEPTH-1 cycles. Worst case takes DEPTH*(DEPTH-1)/2 cycles.
- SORT ignores Wrinit and Rd; DataOut holds its value.
- s falling during SORT is ignored; the sort completes.
- DONE: done=1; Rd reads as in IDLE; Wrinit ignored; swap_cnt holds. s=0 -> IDLE next edge, done drops.
- DEPTH=2 (L=1): a single compare, then DONE.
- swap_cnt width of 2L bits covers the maximum of DEPTH*(DEPTH-1)/2 swaps; it never wraps.

Decomposition:
- Package param_mem_sorter_pkg: state enum (IDLE, SORT, DONE) and a helper function for max swaps.
- Sub-module sort_cmp: combinational, width N.
  - Inputs: a, b, desc, sgn.
  - Output: swap_req.
  - Signed mode compares with inverted MSBs.
- Memory, counters and FSM stay in the top.

Test Plan:
- N=8, L=3; load 16,14,12,10,8,6,4,2 at addresses 0..7; s=1 -> busy for exactly 28 cycles, done=1. Reads at 0..7 return 2,4,6,8,10,12,14,16 one cycle after each address. swap_cnt=28.
- Load 1..8 ascending; s=1 -> done after 7 SORT cycles, swap_cnt=0, contents unchanged.
- desc=1 with the same reverse data -> 16,14,...,2, swap_cnt=0, 7 cycles. Change desc mid-sort on a second run -> no effect on the result.
- sgn=1, load 0x05,0xF0,0x80,0x7F,0x00,0xFF,0x05,0x01 -> 0x80,0xF0,0xFF,0x00,0x01,0x05,0x05,0x7F. sgn=0 on the same load -> 0x00,0x01,0x05,0x05,0x7F,0x80,0xF0,0xFF.
- Wrinit with Radd=3, Datain=0xAA during SORT -> ignored; final sorted contents exclude 0xAA.
- Assert rst 5 cycles into a sort -> done=busy=0 immediately and all reads return 0. After reloading, a new s produces a correct sort.
